// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I main controller: Moore FSM, ALU/immediate decoders, retired-instruction counter.
// Optional RISCV_CTRL_BNE_EN: the BEQ state also resolves bne (funct3 001); other branch funct3 are illegal.
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_legal;
  logic             w_taken;
  logic [1:0]       w_aluOp;
  logic [CNT_W-1:0] r_instret;
  logic             r_pcUpdate, r_branch, r_adrSrc, r_memWrite, r_irWrite, r_regWrite;
  logic [1:0]       r_resultSrc, r_aluSrcA, r_aluSrcB, r_aluOp;

  always_comb begin
    w_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL: w_legal = 1'b1;
`ifdef RISCV_CTRL_BNE_EN
      OP_BR: w_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
      OP_BR: w_legal = 1'b1;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH: w_next = DECODE;
      DECODE: begin
        if (w_legal) begin
          case (op)
            OP_LW, OP_SW: w_next = MEMADR;
            OP_R:         w_next = EXECUTER;
            OP_I:         w_next = EXECUTEI;
            OP_BR:        w_next = BEQ;
            OP_JAL:       w_next = JAL;
            default:      w_next = FETCH;
          endcase
        end
      end
      MEMADR:   w_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  w_next = MEMWB;
      EXECUTER, EXECUTEI, JAL: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  // Controls are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    r_pcUpdate  <= 1'b0;
    r_branch    <= 1'b0;
    r_adrSrc    <= 1'b0;
    r_memWrite  <= 1'b0;
    r_irWrite   <= 1'b0;
    r_regWrite  <= 1'b0;
    r_resultSrc <= 2'b00;
    r_aluSrcA   <= 2'b00;
    r_aluSrcB   <= 2'b00;
    r_aluOp     <= 2'b00;
    if (reset) begin
      r_state     <= FETCH;
      r_instret   <= '0;
      r_irWrite   <= 1'b1;
      r_pcUpdate  <= 1'b1;
      r_aluSrcB   <= 2'b10;
      r_resultSrc <= 2'b10;
    end else begin
      r_state <= w_next;
      if (r_state == MEMWB || r_state == MEMWRITE || r_state == ALUWB || r_state == BEQ)
        r_instret <= r_instret + CNT_W'(1);
      case (w_next)
        FETCH: begin
          r_irWrite   <= 1'b1;
          r_pcUpdate  <= 1'b1;
          r_aluSrcB   <= 2'b10;
          r_resultSrc <= 2'b10;
        end
        DECODE: begin
          r_aluSrcA <= 2'b01;
          r_aluSrcB <= 2'b01;
        end
        MEMADR: begin
          r_aluSrcA <= 2'b10;
          r_aluSrcB <= 2'b01;
        end
        MEMREAD: r_adrSrc <= 1'b1;
        MEMWB: begin
          r_resultSrc <= 2'b01;
          r_regWrite  <= 1'b1;
        end
        MEMWRITE: begin
          r_adrSrc   <= 1'b1;
          r_memWrite <= 1'b1;
        end
        EXECUTER: begin
          r_aluSrcA <= 2'b10;
          r_aluOp   <= 2'b10;
        end
        EXECUTEI: begin
          r_aluSrcA <= 2'b10;
          r_aluSrcB <= 2'b01;
          r_aluOp   <= 2'b10;
        end
        ALUWB: r_regWrite <= 1'b1;
        BEQ: begin
          r_aluSrcA <= 2'b10;
          r_aluOp   <= 2'b01;
          r_branch  <= 1'b1;
        end
        JAL: begin
          r_aluSrcA  <= 2'b01;
          r_aluSrcB  <= 2'b10;
          r_pcUpdate <= 1'b1;
        end
        default: r_irWrite <= 1'b0;
      endcase
    end
  end

`ifdef RISCV_CTRL_BNE_EN
  assign w_taken = Zero ^ funct3[0];
`else
  assign w_taken = Zero;
`endif

  assign w_aluOp = reset ? 2'b00 : r_aluOp;

  always_comb begin
    ALUControl = 3'b000;
    case (w_aluOp)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // While reset is held, enables are suppressed and muxes show their FETCH settings.
  assign PCWrite   = ~reset & (r_pcUpdate | (r_branch & w_taken));
  assign MemWrite  = ~reset & r_memWrite;
  assign IRWrite   = ~reset & r_irWrite;
  assign RegWrite  = ~reset & r_regWrite;
  assign illegal   = ~reset & (r_state == DECODE) & ~w_legal;
  assign AdrSrc    = reset ? 1'b0 : r_adrSrc;
  assign ResultSrc = reset ? 2'b10 : r_resultSrc;
  assign ALUSrcA   = reset ? 2'b00 : r_aluSrcA;
  assign ALUSrcB   = reset ? 2'b10 : r_aluSrcB;
  assign instret   = r_instret;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: per-cycle expected controls queued, then popped and compared.
module tb_riscv_multicycle_ctrl;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } tbState_t;

  typedef struct {
    string       tag;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0]  aluCtl;
    logic [31:0] instret;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, funct7b5, Zero;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  logic        sPCWrite, sAdrSrc, sMemWrite, sIRWrite, sRegWrite, sIllegal;
  logic [1:0]  sResultSrc, sALUSrcA, sALUSrcB, sImmSrc;
  logic [2:0]  sALUControl;
  logic [1:0]  sInstret;

  riscv_multicycle_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .instret(instret)
  );

  // Narrow counter instance exercises the all-ones to zero wrap.
  riscv_multicycle_ctrl #(.CNT_W(2)) u_dutSmall (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(sPCWrite), .AdrSrc(sAdrSrc), .MemWrite(sMemWrite), .IRWrite(sIRWrite),
    .ResultSrc(sResultSrc), .ALUSrcA(sALUSrcA), .ALUSrcB(sALUSrcB), .ALUControl(sALUControl),
    .ImmSrc(sImmSrc), .RegWrite(sRegWrite), .illegal(sIllegal), .instret(sInstret)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned modelCount = 0;
  exp_t        expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic opLegal();
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 1'b1;
`ifdef RISCV_CTRL_BNE_EN
      7'b1100011: return (funct3 == 3'b000) || (funct3 == 3'b001);
`else
      7'b1100011: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] expAluCtl(input logic [1:0] aluOp);
    if (aluOp == 2'b00) return 3'b000;
    if (aluOp == 2'b01) return 3'b001;
    case (funct3)
      3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t expectFor(input tbState_t s, input string tag);
    exp_t e;
    logic [1:0] aluOp;
    e.tag = tag;
    {e.pcWrite, e.adrSrc, e.memWrite, e.irWrite, e.regWrite, e.illegal} = '0;
    e.resultSrc = 2'b00; e.aluSrcA = 2'b00; e.aluSrcB = 2'b00;
    aluOp = 2'b00;
    case (op)
      7'b0100011: e.immSrc = 2'b01;
      7'b1100011: e.immSrc = 2'b10;
      7'b1101111: e.immSrc = 2'b11;
      default:    e.immSrc = 2'b00;
    endcase
    if (reset) begin
      e.aluSrcB = 2'b10; e.resultSrc = 2'b10;
    end else begin
      case (s)
        S_FETCH:    begin e.irWrite = 1; e.pcWrite = 1; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; end
        S_DECODE:   begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; e.illegal = !opLegal(); end
        S_MEMADR:   begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; end
        S_MEMREAD:  e.adrSrc = 1;
        S_MEMWB:    begin e.resultSrc = 2'b01; e.regWrite = 1; end
        S_MEMWRITE: begin e.adrSrc = 1; e.memWrite = 1; end
        S_EXECR:    begin e.aluSrcA = 2'b10; aluOp = 2'b10; end
        S_EXECI:    begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; aluOp = 2'b10; end
        S_ALUWB:    e.regWrite = 1;
        S_BEQ: begin
          e.aluSrcA = 2'b10; aluOp = 2'b01;
`ifdef RISCV_CTRL_BNE_EN
          e.pcWrite = Zero ^ funct3[0];
`else
          e.pcWrite = Zero;
`endif
        end
        S_JAL:      begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.pcWrite = 1; end
        default:    e.irWrite = 0;
      endcase
    end
    e.aluCtl = expAluCtl(aluOp);
    e.instret = modelCount;
    return e;
  endfunction

  task automatic stepCycle(input tbState_t s, input string tag);
    exp_t e;
    expQ.push_back(expectFor(s, tag));
    #1;
    e = expQ.pop_front();
    checkOutput({e.tag, ".PCWrite"},    32'(PCWrite),    32'(e.pcWrite));
    checkOutput({e.tag, ".AdrSrc"},     32'(AdrSrc),     32'(e.adrSrc));
    checkOutput({e.tag, ".MemWrite"},   32'(MemWrite),   32'(e.memWrite));
    checkOutput({e.tag, ".IRWrite"},    32'(IRWrite),    32'(e.irWrite));
    checkOutput({e.tag, ".RegWrite"},   32'(RegWrite),   32'(e.regWrite));
    checkOutput({e.tag, ".illegal"},    32'(illegal),    32'(e.illegal));
    checkOutput({e.tag, ".ResultSrc"},  32'(ResultSrc),  32'(e.resultSrc));
    checkOutput({e.tag, ".ALUSrcA"},    32'(ALUSrcA),    32'(e.aluSrcA));
    checkOutput({e.tag, ".ALUSrcB"},    32'(ALUSrcB),    32'(e.aluSrcB));
    checkOutput({e.tag, ".ALUControl"}, 32'(ALUControl), 32'(e.aluCtl));
    checkOutput({e.tag, ".ImmSrc"},     32'(ImmSrc),     32'(e.immSrc));
    checkOutput({e.tag, ".instret"},    instret,         e.instret);
    checkOutput({e.tag, ".instretWrap"}, 32'(sInstret),  e.instret % 4);
    if (reset) modelCount = 0;
    else if (s == S_MEMWB || s == S_MEMWRITE || s == S_ALUWB || s == S_BEQ) modelCount++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input string tag);
    tbState_t path[$];
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    path = {S_FETCH, S_DECODE};
    if (opLegal()) begin
      case (o)
        7'b0000011: path = {path, S_MEMADR, S_MEMREAD, S_MEMWB};
        7'b0100011: path = {path, S_MEMADR, S_MEMWRITE};
        7'b0110011: path = {path, S_EXECR, S_ALUWB};
        7'b0010011: path = {path, S_EXECI, S_ALUWB};
        7'b1100011: path = {path, S_BEQ};
        default:    path = {path, S_JAL, S_ALUWB};
      endcase
    end
    foreach (path[i]) stepCycle(path[i], $sformatf("%s.c%0d", tag, i + 1));
  endtask

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    @(negedge clk);
    stepCycle(S_FETCH, "rst1");
    stepCycle(S_FETCH, "rst2");
    reset = 1'b0;

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, "sub");
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, "add");
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, "and");
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, "slt");
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, "addi");
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0, "ori");
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, "beqT");
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, "beqN");
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, "ill");
    applyStimulus(7'b0010011, 3'b011, 1'b0, 1'b0, "sltiu");

    // lw abandoned by reset in MEMREAD
    op = 7'b0000011; funct3 = 3'b010;
    stepCycle(S_FETCH, "abort.c1");
    stepCycle(S_DECODE, "abort.c2");
    stepCycle(S_MEMADR, "abort.c3");
    reset = 1'b1;
    stepCycle(S_MEMREAD, "abort.rst");
    reset = 1'b0;
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, "lwAfter");
    stepCycle(S_FETCH, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Main controller for the multicycle RV32I datapath (PC, IR, register file, ALU, immediate extender, unified memory).
- Moore FSM sequences each instruction over 3–5 cycles and drives all mux selects and write enables, including ImmSrc for the immediate extender.
- Also keeps a retired-instruction counter for the debug/perf path.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select (0 = PC, 1 = ALUOut)
MemWrite  output  1  memory write enable
IRWrite  output  1  IR/OldPC enable
ResultSrc  output  2  result mux (00 = ALUOut, 01 = Data, 10 = ALUResult)
ALUSrcA  output  2  A mux (00 = PC, 01 = OldPC, 10 = rs1 reg)
ALUSrcB  output  2  B mux (00 = rs2 reg, 01 = ImmExt, 10 = constant 4)
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
RegWrite  output  1  register file write enable
illegal  output  1  one-cycle pulse: unsupported opcode seen in DECODE
instret  output  CNT_W  retired-instruction count

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Reset has priority over every transition.
- On reset: state <= FETCH, instret <= 0.
- While reset is high, PCWrite, MemWrite, IRWrite, RegWrite and illegal are forced to 0. All other outputs take their FETCH values.
- Reset asserted mid-instruction abandons that instruction. It is not counted.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - Any other op -> FETCH, with illegal = 1 in that DECODE cycle.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Outputs (Moore; every signal not listed is 0). ALUOp is internal: 00 add, 01 sub, 10 funct-decoded.
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (branch/jump target into ALUOut).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
- PCWrite = PCUpdate | (Branch & Zero). Combinational; Zero is sampled in the BEQ cycle.
- ALU decoder (combinational):
  - ALUOp 00 -> 000. ALUOp 01 -> 001.
  - ALUOp 10, by funct3:
    - 000: sub (001) if op[5] & funct7b5, else add (000).
    - 010 -> 101. 110 -> 011. 111 -> 010.
    - Any other funct3 -> 000.
- ImmSrc is decoded combinationally from op in every state:
  - 0000011 or 0010011 -> 00.
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - Otherwise -> 00.
- Latency in cycles: lw 5; sw, R-type, I-type and jal 4; beq 3 (taken or not). Illegal opcode: 2 cycles.
- instret increments by 1 on every clock edge where the state is MEMWB, MEMWRITE, ALUWB or BEQ (jal counted once, via ALUWB). Illegal opcodes are never counted. instret wraps from all-ones to 0.

Optional Feature:
- Macro: RISCV_CTRL_BNE_EN.
- Defined:
  - BEQ state handles both beq (funct3 000) and bne (funct3 001).
  - PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])).
  - Op 1100011 with any other funct3 -> FETCH with illegal pulse, not counted.
- Undefined:
  - Any funct3 under op 1100011 is treated as beq.

Test Plan:
1. reset held 2 cycles, then released with op = 0000011 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite = 1 only in cycle 5. instret 0 -> 1. Write enables are 0 during reset.
2. sw (op 0100011) -> MemWrite = 1 and AdrSrc = 1 in cycle 4 only; ImmSrc = 01 throughout; instret +1.
3. R-type (op 0110011) with funct3 000 and funct7b5 = 1 -> ALUControl = 001 in EXECUTER. Same with funct7b5 = 0 -> 000. funct3 111 -> 010.
4. beq with Zero = 1 -> PCWrite = 1 in cycle 3. With Zero = 0 -> PCWrite = 0. Both cases return to FETCH at cycle 4.
5. jal (op 1101111) -> ImmSrc = 11. In JAL: PCWrite = 1, ALUSrcA = 01, ALUSrcB = 10. ALUWB writes the register. 4 cycles; instret +1.
6. op = 1111111 -> illegal = 1 in DECODE, back to FETCH, instret unchanged. Also: instret preloaded to all-ones retires one instruction -> wraps to 0. reset asserted during MEMREAD -> FETCH next cycle, no RegWrite.
